// File: rtl/dmem_copy_engine_if.sv
// Data-memory bus between dmem_copy_engine (master) and the dmem array (slave).
// ReadData is combinational on Address/RDMEM; writes commit on the rising clock edge.
interface dmem_copy_engine_if;
  logic [23:0] Address;
  logic [31:0] WriteData;
  logic        WRMEM;
  logic        RDMEM;
  logic [31:0] ReadData;

  modport master (output Address, output WriteData, output WRMEM, output RDMEM, input ReadData);
  modport slave  (input Address, input WriteData, input WRMEM, input RDMEM, output ReadData);
endinterface

// File: rtl/dmem_copy_engine.sv
// Block copy / fill engine mastering the dmem port; all bus outputs are registered.
// Optional running checksum of written words is enabled by DMEM_COPY_CHECKSUM_EN.
module dmem_copy_engine #(
  parameter int MEM_DEPTH = 1025,
  parameter int LEN_W     = 11
) (
  input  logic                 Clk,
  input  logic                 Rst_n,
  input  logic                 Start,
  input  logic                 Mode,
  input  logic [23:0]          SrcAddr,
  input  logic [23:0]          DstAddr,
  input  logic [LEN_W-1:0]     Length,
  input  logic [31:0]          FillValue,
  dmem_copy_engine_if.master   dmem,
  output logic                 Busy,
  output logic                 Done,
  output logic                 Err,
  output logic [31:0]          Checksum,
  output logic [1:0]           dbg_state_o
);

  typedef enum logic [1:0] {S_IDLE, S_READ, S_WRITE, S_DONE} state_t;

  state_t           state_q;
  logic             mode_q;
  logic [23:0]      src_q;
  logic [23:0]      dst_q;
  logic [LEN_W-1:0] len_q;
  logic [LEN_W-1:0] i_q;
  logic [23:0]      address_q;
  logic [31:0]      wdata_q;
  logic             wrmem_q;
  logic             rdmem_q;
  logic             busy_q;
  logic             done_q;
  logic             err_q;

  logic [24:0]      dst_end;
  logic [24:0]      src_end;
  logic             range_err;
  logic [LEN_W-1:0] i_next;
  logic             last_word;

  // 25-bit sums so a range near the top of the address space cannot wrap.
  assign dst_end   = {1'b0, DstAddr} + 25'(Length);
  assign src_end   = {1'b0, SrcAddr} + 25'(Length);
  assign range_err = (dst_end > 25'(MEM_DEPTH)) || (!Mode && (src_end > 25'(MEM_DEPTH)));
  assign i_next    = i_q + LEN_W'(1);
  assign last_word = (i_q == len_q - LEN_W'(1));

`ifdef DMEM_COPY_CHECKSUM_EN
  logic [31:0] csum_q;
  assign Checksum = csum_q;
`else
  assign Checksum = '0;
`endif

  // wdata_q doubles as the copy buffer: ReadData captured in READ is the next WRITE's data.
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      state_q   <= S_IDLE;
      mode_q    <= 1'b0;
      src_q     <= '0;
      dst_q     <= '0;
      len_q     <= '0;
      i_q       <= '0;
      address_q <= '0;
      wdata_q   <= '0;
      wrmem_q   <= 1'b0;
      rdmem_q   <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
`ifdef DMEM_COPY_CHECKSUM_EN
      csum_q    <= '0;
`endif
    end else begin
      case (state_q)
        S_IDLE: begin
          if (Start) begin
            mode_q <= Mode;
            src_q  <= SrcAddr;
            dst_q  <= DstAddr;
            len_q  <= Length;
            i_q    <= '0;
`ifdef DMEM_COPY_CHECKSUM_EN
            csum_q <= '0;
`endif
            if (Length == '0) begin
              state_q <= S_DONE;
              done_q  <= 1'b1;
              err_q   <= 1'b0;
            end else if (range_err) begin
              state_q <= S_DONE;
              done_q  <= 1'b1;
              err_q   <= 1'b1;
            end else if (!Mode) begin
              state_q   <= S_READ;
              address_q <= SrcAddr;
              rdmem_q   <= 1'b1;
              busy_q    <= 1'b1;
            end else begin
              state_q   <= S_WRITE;
              address_q <= DstAddr;
              wdata_q   <= FillValue;
              wrmem_q   <= 1'b1;
              busy_q    <= 1'b1;
            end
          end
        end
        S_READ: begin
          state_q   <= S_WRITE;
          wdata_q   <= dmem.ReadData;
          address_q <= dst_q + 24'(i_q);
          rdmem_q   <= 1'b0;
          wrmem_q   <= 1'b1;
        end
        S_WRITE: begin
          i_q <= i_next;
`ifdef DMEM_COPY_CHECKSUM_EN
          csum_q <= csum_q + wdata_q;
`endif
          if (last_word) begin
            state_q   <= S_DONE;
            address_q <= '0;
            wdata_q   <= '0;
            wrmem_q   <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b1;
            err_q     <= 1'b0;
          end else if (!mode_q) begin
            state_q   <= S_READ;
            address_q <= src_q + 24'(i_next);
            wdata_q   <= '0;
            wrmem_q   <= 1'b0;
            rdmem_q   <= 1'b1;
          end else begin
            address_q <= dst_q + 24'(i_next);
          end
        end
        S_DONE: begin
          state_q <= S_IDLE;
          done_q  <= 1'b0;
          err_q   <= 1'b0;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign dmem.Address   = address_q;
  assign dmem.WriteData = wdata_q;
  assign dmem.WRMEM     = wrmem_q;
  assign dmem.RDMEM     = rdmem_q;
  assign Busy           = busy_q;
  assign Done           = done_q;
  assign Err            = err_q;
  assign dbg_state_o    = state_q;

endmodule

// File: tb/tb_dmem_copy_engine.sv
// Self-checking bench for dmem_copy_engine: directed scenarios plus randomized commands
// checked against an array-level reference memory and closed-form cycle timing.
module tb_dmem_copy_engine;
  localparam int DEPTH = 1025;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic        mode;
  logic [23:0] src_addr;
  logic [23:0] dst_addr;
  logic [10:0] length;
  logic [31:0] fill_value;
  logic        busy, done, err;
  logic [31:0] checksum;
  logic [1:0]  dbg_state;

  logic        pre_we = 1'b0;
  logic [23:0] pre_addr = '0;
  logic [31:0] pre_data = '0;
  logic [31:0] mem     [0:DEPTH-1];
  logic [31:0] ref_mem [0:DEPTH-1];

  int checks = 0;
  int errors = 0;

  dmem_copy_engine_if bus ();

  dmem_copy_engine #(.MEM_DEPTH(DEPTH), .LEN_W(11)) dut (
    .Clk(clk), .Rst_n(rst_n), .Start(start), .Mode(mode),
    .SrcAddr(src_addr), .DstAddr(dst_addr), .Length(length), .FillValue(fill_value),
    .dmem(bus.master), .Busy(busy), .Done(done), .Err(err), .Checksum(checksum),
    .dbg_state_o(dbg_state)
  );

  always #5 clk = ~clk;

  // dmem model: combinational read, write on the rising edge; pre_we is a bench-only preload path.
  assign bus.ReadData = bus.RDMEM ? mem[bus.Address] : 32'h0;
  always @(posedge clk) begin
    if (bus.WRMEM) mem[bus.Address] <= bus.WriteData;
    else if (pre_we) mem[pre_addr] <= pre_data;
  end

  function automatic int mem_diff();
    int d = 0;
    for (int k = 0; k < DEPTH; k++) if (mem[k] !== ref_mem[k]) d++;
    return d;
  endfunction

  // Reference: ascending word-by-word move; returns the sum of written words.
  function automatic logic [31:0] model_cmd(input logic m, input int s, input int d, input int n,
                                            input logic [31:0] f);
    logic [31:0] sum = 0;
    logic [31:0] v;
    for (int k = 0; k < n; k++) begin
      v = m ? f : ref_mem[s + k];
      ref_mem[d + k] = v;
      sum += v;
    end
    return sum;
  endfunction

  function automatic logic [31:0] exp_csum(input logic [31:0] s);
`ifdef DMEM_COPY_CHECKSUM_EN
    return s;
`else
    return 32'h0 & s;
`endif
  endfunction

  task automatic poke(input int a, input logic [31:0] v);
    @(negedge clk);
    pre_we = 1'b1; pre_addr = 24'(a); pre_data = v; ref_mem[a] = v;
    @(negedge clk);
    pre_we = 1'b0;
  endtask

  task automatic preload_all();
    @(negedge clk);
    for (int k = 0; k < DEPTH; k++) begin
      pre_we = 1'b1; pre_addr = 24'(k); pre_data = $urandom; ref_mem[k] = pre_data;
      @(negedge clk);
    end
    pre_we = 1'b0;
  endtask

  // Drives one command and watches the bus each cycle until Done (cycle 1 = first after accept).
  task automatic issue_cmd(input logic m, input int s, input int d, input int n,
                           input logic [31:0] f, input int poke_cyc,
                           output int done_cyc, output logic err_seen, output int rd_n,
                           output int wr_n, output int bad_n, output logic [31:0] csum);
    done_cyc = -1; err_seen = 1'bx; rd_n = 0; wr_n = 0; bad_n = 0; csum = 'x;
    @(negedge clk);
    start = 1'b1; mode = m; src_addr = 24'(s); dst_addr = 24'(d);
    length = 11'(n); fill_value = f;
    @(posedge clk);
    #1 start = 1'b0;
    for (int cyc = 1; cyc <= 100; cyc++) begin
      @(negedge clk);
      start = (cyc == poke_cyc);
      if (cyc == poke_cyc) begin
        mode = ~m; dst_addr = 24'($urandom_range(0, 1000)); length = 11'($urandom_range(1, 9));
      end
      rd_n += int'(bus.RDMEM);
      wr_n += int'(bus.WRMEM);
      if ((bus.RDMEM && bus.WRMEM) || (busy !== (bus.RDMEM | bus.WRMEM)) || (err && !done)) bad_n++;
      if (done && (bus.Address !== 0 || bus.WriteData !== 0 || busy)) bad_n++;
      if (done) begin
        done_cyc = cyc; err_seen = err; csum = checksum;
        break;
      end
    end
    start = 1'b0;
  endtask

  task automatic test_reset();
    logic [95:0] obs;
    obs = {bus.Address, bus.WriteData, bus.WRMEM, bus.RDMEM, busy, done, err, dbg_state, checksum[24:0]};
    checks++;
    if (obs !== 96'h0) begin
      errors++; $display("FAIL reset_outputs: got %h required 0", obs);
    end
  endtask

  task automatic test_copy_basic();
    int dc, rn, wn, bn; logic e; logic [31:0] cs, es;
    for (int k = 0; k < 4; k++) poke(16 + k, 32'(k + 1));
    es = model_cmd(1'b0, 16, 256, 4, 0);
    issue_cmd(1'b0, 16, 256, 4, 32'h0, 0, dc, e, rn, wn, bn, cs);
    checks++; if (dc !== 9) begin errors++; $display("FAIL copy_done_cycle: got %0d required 9", dc); end
    checks++; if (e !== 1'b0) begin errors++; $display("FAIL copy_err: got %b required 0", e); end
    checks++; if (rn !== 4 || wn !== 4) begin errors++; $display("FAIL copy_strobes: rd %0d wr %0d required 4 4", rn, wn); end
    checks++; if (bn !== 0) begin errors++; $display("FAIL copy_protocol: %0d bad cycles required 0", bn); end
    checks++; if (cs !== exp_csum(32'h0A)) begin errors++; $display("FAIL copy_checksum: got %h required %h", cs, exp_csum(es)); end
    checks++; if ({mem[256], mem[257], mem[258], mem[259]} !== {32'd1, 32'd2, 32'd3, 32'd4}) begin
      errors++; $display("FAIL copy_data: got %0d %0d %0d %0d required 1 2 3 4", mem[256], mem[257], mem[258], mem[259]);
    end
  endtask

  task automatic test_fill();
    int dc, rn, wn, bn; logic e; logic [31:0] cs, es;
    es = model_cmd(1'b1, 0, 512, 3, 32'hDEADBEEF);
    issue_cmd(1'b1, 0, 512, 3, 32'hDEADBEEF, 0, dc, e, rn, wn, bn, cs);
    checks++; if (dc !== 4 || e !== 1'b0) begin errors++; $display("FAIL fill_done: cycle %0d err %b required 4 0", dc, e); end
    checks++; if (rn !== 0 || wn !== 3) begin errors++; $display("FAIL fill_strobes: rd %0d wr %0d required 0 3", rn, wn); end
    checks++; if (cs !== exp_csum(es)) begin errors++; $display("FAIL fill_checksum: got %h required %h", cs, exp_csum(es)); end
    checks++; if (mem_diff() !== 0) begin errors++; $display("FAIL fill_mem: %0d words differ required 0", mem_diff()); end
  endtask

  task automatic test_range_err();
    int dc, rn, wn, bn; logic e; logic [31:0] cs, es;
    issue_cmd(1'b0, 0, 1020, 6, 32'h0, 0, dc, e, rn, wn, bn, cs);
    checks++; if (dc !== 1 || e !== 1'b1) begin errors++; $display("FAIL range_err_done: cycle %0d err %b required 1 1", dc, e); end
    checks++; if (rn !== 0 || wn !== 0) begin errors++; $display("FAIL range_err_strobes: rd %0d wr %0d required 0 0", rn, wn); end
    issue_cmd(1'b1, 0, 1020, 6, 32'h5, 0, dc, e, rn, wn, bn, cs);
    checks++; if (dc !== 1 || e !== 1'b1 || wn !== 0) begin errors++; $display("FAIL range_err_fill: cycle %0d err %b wr %0d required 1 1 0", dc, e, wn); end
    checks++; if (mem_diff() !== 0) begin errors++; $display("FAIL range_err_mem: %0d words differ required 0", mem_diff()); end
    // Exactly at the top of memory is legal.
    es = model_cmd(1'b1, 0, 1019, 6, 32'h1234);
    issue_cmd(1'b1, 0, 1019, 6, 32'h1234, 0, dc, e, rn, wn, bn, cs);
    checks++; if (dc !== 7 || e !== 1'b0 || wn !== 6) begin errors++; $display("FAIL range_edge: cycle %0d err %b wr %0d required 7 0 6", dc, e, wn); end
    checks++; if (mem_diff() !== 0 || cs !== exp_csum(es)) begin errors++; $display("FAIL range_edge_mem: diff %0d csum %h required 0 %h", mem_diff(), cs, exp_csum(es)); end
  endtask

  task automatic test_len_zero();
    int dc, rn, wn, bn; logic e; logic [31:0] cs;
    issue_cmd(1'b0, 5, 9, 0, 32'h0, 0, dc, e, rn, wn, bn, cs);
    checks++; if (dc !== 1 || e !== 1'b0) begin errors++; $display("FAIL len_zero_done: cycle %0d err %b required 1 0", dc, e); end
    checks++; if (rn !== 0 || wn !== 0 || cs !== 0) begin errors++; $display("FAIL len_zero_strobes: rd %0d wr %0d csum %h required 0 0 0", rn, wn, cs); end
  endtask

  task automatic test_ignored_start();
    int dc, rn, wn, bn, extra; logic e; logic [31:0] cs;
    void'(model_cmd(1'b0, 48, 640, 4, 0));
    issue_cmd(1'b0, 48, 640, 4, 32'h0, 3, dc, e, rn, wn, bn, cs);
    extra = 0;
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      if (done || busy) extra++;
    end
    checks++; if (dc !== 9 || wn !== 4) begin errors++; $display("FAIL ignored_start_done: cycle %0d wr %0d required 9 4", dc, wn); end
    checks++; if (extra !== 0) begin errors++; $display("FAIL ignored_start_queued: %0d active cycles required 0", extra); end
    checks++; if (mem_diff() !== 0) begin errors++; $display("FAIL ignored_start_mem: %0d words differ required 0", mem_diff()); end
  endtask

  task automatic test_overlap();
    int dc, rn, wn, bn; logic e; logic [31:0] cs;
    poke(32, 32'hA); poke(33, 32'hB); poke(34, 32'hC);
    void'(model_cmd(1'b0, 32, 33, 3, 0));
    issue_cmd(1'b0, 32, 33, 3, 32'h0, 0, dc, e, rn, wn, bn, cs);
    checks++; if ({mem[33], mem[34], mem[35]} !== {32'hA, 32'hA, 32'hA}) begin
      errors++; $display("FAIL overlap_data: got %h %h %h required a a a", mem[33], mem[34], mem[35]);
    end
    checks++; if (dc !== 7 || mem_diff() !== 0) begin errors++; $display("FAIL overlap_done: cycle %0d diff %0d required 7 0", dc, mem_diff()); end
  endtask

  task automatic test_reset_mid_copy();
    int dc, rn, wn, bn, seen; logic e; logic [31:0] cs;
    logic [95:0] obs;
    @(negedge clk);
    start = 1'b1; mode = 1'b0; src_addr = 24'd768; dst_addr = 24'd832; length = 11'd4;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (4) @(negedge clk);
    #2 rst_n = 1'b0;
    #1 obs = {bus.Address, bus.WriteData, bus.WRMEM, bus.RDMEM, busy, done, err, dbg_state, checksum[24:0]};
    checks++; if (obs !== 96'h0) begin errors++; $display("FAIL reset_async: got %h required 0", obs); end
    @(negedge clk) rst_n = 1'b1;
    seen = 0;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      if (done) seen++;
    end
    checks++; if (seen !== 0) begin errors++; $display("FAIL reset_no_done: %0d pulses required 0", seen); end
    ref_mem[832] = ref_mem[768];
    checks++; if (mem_diff() !== 0) begin errors++; $display("FAIL reset_partial_mem: %0d words differ required 0", mem_diff()); end
    void'(model_cmd(1'b0, 768, 832, 4, 0));
    issue_cmd(1'b0, 768, 832, 4, 32'h0, 0, dc, e, rn, wn, bn, cs);
    checks++; if (dc !== 9 || mem_diff() !== 0) begin errors++; $display("FAIL reset_recover: cycle %0d diff %0d required 9 0", dc, mem_diff()); end
  endtask

  task automatic test_random();
    int dc, rn, wn, bn, n, s, d, xd, xr, xw; logic e, m, xe; logic [31:0] cs, f, es;
    for (int t = 0; t < 30; t++) begin
      m = 1'($urandom_range(0, 1)); n = $urandom_range(0, 12);
      s = $urandom_range(0, 1030); d = $urandom_range(0, 1030); f = $urandom;
      xe = (n != 0) && ((d + n > DEPTH) || (!m && (s + n > DEPTH)));
      es = 0;
      if (n == 0 || xe) begin xd = 1; xr = 0; xw = 0; end
      else begin
        xd = m ? n + 1 : 2 * n + 1; xr = m ? 0 : n; xw = n;
        es = model_cmd(m, s, d, n, f);
      end
      issue_cmd(m, s, d, n, f, 0, dc, e, rn, wn, bn, cs);
      checks++;
      if (dc !== xd || e !== xe || rn !== xr || wn !== xw || bn !== 0 || cs !== exp_csum(es)) begin
        errors++;
        $display("FAIL random_cmd %0d: done %0d err %b rd %0d wr %0d bad %0d csum %h required %0d %b %0d %0d 0 %h",
                 t, dc, e, rn, wn, bn, cs, xd, xe, xr, xw, exp_csum(es));
      end
    end
    checks++; if (mem_diff() !== 0) begin errors++; $display("FAIL random_mem: %0d words differ required 0", mem_diff()); end
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; mode = 1'b0; src_addr = '0; dst_addr = '0;
    length = '0; fill_value = '0;
    repeat (3) @(negedge clk);
    test_reset();
    rst_n = 1'b1;
    preload_all();
    test_copy_basic();
    test_fill();
    test_range_err();
    test_len_zero();
    test_ignored_start();
    test_overlap();
    test_reset_mid_copy();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
